// File: rtl/conv_kern_ctrl_pkg.sv
// Shared definitions for the convolution kernel controller: state encoding,
// default geometry and the beat-count helper.
package conv_kern_ctrl_pkg;

    localparam int DEF_N         = 16;
    localparam int DEF_ADDR_BITS = 16;
    localparam int BEAT_W        = 9;   // wide enough for 256 channels at N=1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Input-channel count 0 stands for 256; result is ceil(in_ch / n).
    function automatic logic [BEAT_W-1:0] calc_beats(input logic [7:0] in_ch, input int n);
        int eff;
        eff = (in_ch == 8'd0) ? 256 : int'(in_ch);
        return BEAT_W'((eff + n - 1) / n);
    endfunction

endpackage

// File: rtl/conv_kern_ctrl_loop_cnt.sv
// Nested pixel / output-channel / beat counter (beat innermost) with
// wrap flags for each level and a flag for the very last beat of the job.
module conv_loop_cnt
    import conv_kern_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              en,
    input  logic [BEAT_W-1:0] beats,
    input  logic [7:0]        out_ch,
    input  logic [15:0]       num_pix,
    output logic [7:0]        oc,
    output logic              wrap_beat,
    output logic              wrap_oc,
    output logic              last
);

    localparam logic [BEAT_W-1:0] ONE_B = 1;

    logic [BEAT_W-1:0] beat_reg;
    logic [7:0]        oc_reg;
    logic [15:0]       pix_reg;

    assign wrap_beat = (beat_reg == beats - ONE_B);
    assign wrap_oc   = (oc_reg == out_ch - 8'd1);
    assign last      = wrap_beat && wrap_oc && (pix_reg == num_pix - 16'd1);
    assign oc        = oc_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_reg <= '0;
            oc_reg   <= '0;
            pix_reg  <= '0;
        end else if (clear) begin
            beat_reg <= '0;
            oc_reg   <= '0;
            pix_reg  <= '0;
        end else if (en) begin
            if (!wrap_beat) begin
                beat_reg <= beat_reg + ONE_B;
            end else begin
                beat_reg <= '0;
                if (!wrap_oc) begin
                    oc_reg <= oc_reg + 8'd1;
                end else begin
                    oc_reg  <= '0;
                    pix_reg <= pix_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_kern_ctrl.sv
// Convolution kernel controller: walks pixel/out-channel/beat loops, issues
// buffer addresses to the conv kernel and waits for every result before done.
module conv_kern_ctrl
    import conv_kern_ctrl_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [7:0]           cfg_in_ch,
    input  logic [7:0]           cfg_out_ch,
    input  logic [15:0]          cfg_num_pix,
    input  logic                 cfg_is_conv3x3,
    input  logic                 src_rdy,
    input  logic                 acc_vld,
    output logic                 kern_vld,
    output logic                 kern_is_conv3x3,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic [ADDR_BITS-1:0] wb_addr,
    output logic [7:0]           param_addr,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_BITS-1:0] ONE_A = 1;

    state_t                state_reg;
    logic [BEAT_W-1:0]     beats_reg;
    logic [7:0]            out_ch_reg;
    logic [15:0]           num_pix_reg;
    logic [23:0]           total_reg;
    logic [23:0]           res_cnt_reg;
    logic [23:0]           res_cnt_next;
    logic [ADDR_BITS-1:0]  fb_addr_reg;
    logic [ADDR_BITS-1:0]  wb_addr_reg;
    logic [ADDR_BITS-1:0]  pix_base_reg;
    logic                  mode_reg;
    logic                  accept;
    logic                  issue;
    logic                  empty_cfg;
    logic                  wrap_beat;
    logic                  wrap_oc;
    logic                  last_beat;
    logic [7:0]            oc;

    assign accept       = (state_reg == ST_IDLE) && start;
    assign issue        = (state_reg == ST_ISSUE) && src_rdy;
    assign empty_cfg    = (cfg_out_ch == 8'd0) || (cfg_num_pix == 16'd0);
    assign res_cnt_next = res_cnt_reg + {23'd0, acc_vld};

    conv_loop_cnt u_loop (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (accept),
        .en        (issue),
        .beats     (beats_reg),
        .out_ch    (out_ch_reg),
        .num_pix   (num_pix_reg),
        .oc        (oc),
        .wrap_beat (wrap_beat),
        .wrap_oc   (wrap_oc),
        .last      (last_beat)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            beats_reg    <= '0;
            out_ch_reg   <= '0;
            num_pix_reg  <= '0;
            total_reg    <= '0;
            res_cnt_reg  <= '0;
            fb_addr_reg  <= '0;
            wb_addr_reg  <= '0;
            pix_base_reg <= '0;
            mode_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        beats_reg    <= calc_beats(cfg_in_ch, N);
                        out_ch_reg   <= cfg_out_ch;
                        num_pix_reg  <= cfg_num_pix;
                        total_reg    <= 24'(cfg_num_pix) * 24'(cfg_out_ch);
                        mode_reg     <= cfg_is_conv3x3;
                        res_cnt_reg  <= '0;
                        fb_addr_reg  <= '0;
                        wb_addr_reg  <= '0;
                        pix_base_reg <= '0;
                        state_reg    <= empty_cfg ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_cnt_reg <= res_cnt_next;
                    if (issue) begin
                        // Addresses are stepped incrementally instead of multiplied:
                        // a new channel rewinds fb to the pixel base, a new pixel rewinds wb.
                        if (!wrap_beat) begin
                            fb_addr_reg <= fb_addr_reg + ONE_A;
                            wb_addr_reg <= wb_addr_reg + ONE_A;
                        end else if (!wrap_oc) begin
                            fb_addr_reg <= pix_base_reg;
                            wb_addr_reg <= wb_addr_reg + ONE_A;
                        end else begin
                            fb_addr_reg  <= fb_addr_reg + ONE_A;
                            pix_base_reg <= fb_addr_reg + ONE_A;
                            wb_addr_reg  <= '0;
                        end
                        if (last_beat) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    res_cnt_reg <= res_cnt_next;
                    if (res_cnt_next >= total_reg) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE:  state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign kern_vld        = issue;
    assign kern_is_conv3x3 = mode_reg;
    assign fb_addr         = fb_addr_reg;
    assign wb_addr         = wb_addr_reg;
    assign param_addr      = oc;
    assign busy            = (state_reg != ST_IDLE);
    assign done            = (state_reg == ST_DONE);

endmodule
